// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO, baud divider and
// configurable frame (data width, parity, stop bits, bit order).
// Words arrive over a tx_rdy/tx_ack handshake and are sent back-to-back.
module uart_tx_fifo #(
  parameter int    DATA_BITS    = 8,
  parameter string PARITY       = "ODD",
  parameter int    STOP_BIT     = 1,
  parameter int    CLKS_PER_BIT = 16,
  parameter int    FIFO_DEPTH   = 4,
  parameter int    LSB_FIRST    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_rdy,
  output logic                        tx_ack,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam bit HAS_PAR = (PARITY != "NONE");
  localparam bit ODD_PAR = (PARITY == "ODD");

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  // Unsupported parameter sets stop elaboration rather than build silently.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 ||
        !(PARITY == "NONE" || PARITY == "ODD" || PARITY == "EVEN") ||
        STOP_BIT < 1 || STOP_BIT > 2 || CLKS_PER_BIT < 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        LSB_FIRST < 0 || LSB_FIRST > 1) begin : g_bad_param
      $error("uart_tx_fifo: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // FIFO
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_ack;
  logic                 w_push, w_pop, w_empty, w_full;
  logic [DATA_BITS-1:0] w_rd_data;
  logic                 w_par_in;

  // Serializer
  state_t               r_state, w_state_nx;
  logic [BW-1:0]        r_baud, w_baud_nx;
  logic [3:0]           r_bit, w_bit_nx;
  logic [DATA_BITS-1:0] r_shift, w_shifted;
  logic                 r_par, r_tx, w_tx_nx, w_shift_en;
  logic                 w_tick, w_cur_bit, w_nxt_bit;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  // Full is judged on current occupancy, so a same-edge pop never frees a slot.
  assign w_push    = tx_rdy && !r_ack && !w_full;
  assign w_rd_data = r_mem[r_rptr];
  assign w_par_in  = ODD_PAR ? ~^w_rd_data : ^w_rd_data;

  // The outgoing bit is always at the "head" end of the shift register.
  assign w_shifted = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
  assign w_cur_bit = (LSB_FIRST != 0) ? r_shift[0]     : r_shift[DATA_BITS-1];
  assign w_nxt_bit = (LSB_FIRST != 0) ? w_shifted[0]   : w_shifted[DATA_BITS-1];
  assign w_tick    = (r_baud == BAUD_LAST);

  assign tx_ack     = r_ack;
  assign tx         = r_tx;
  assign tx_busy    = (r_state != S_IDLE);
  assign fifo_count = r_count;
  assign fifo_full  = w_full;

  // FIFO storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  // FIFO pointers, occupancy and the one-cycle accept pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ack   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_ack   <= w_push;
    end
  end

  // Serializer state, counters, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_tx    <= w_tx_nx;
      if (w_pop) begin
        r_shift <= w_rd_data;
        r_par   <= w_par_in;
      end else if (w_shift_en) begin
        r_shift <= w_shifted;
      end
    end
  end

  // Next state; tx is computed one cycle ahead so the pin stays registered.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = w_tick ? '0 : r_baud + 1'b1;
    w_bit_nx   = r_bit;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;
    w_shift_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        w_bit_nx  = '0;
        w_tx_nx   = 1'b1;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = S_START;
          w_tx_nx    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nx = S_DATA;
          w_bit_nx   = '0;
          w_tx_nx    = w_cur_bit;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == DATA_LAST) begin
            w_bit_nx = '0;
            if (HAS_PAR) begin
              w_state_nx = S_PAR;
              w_tx_nx    = r_par;
            end else begin
              w_state_nx = S_STOP;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_bit_nx   = r_bit + 1'b1;
            w_shift_en = 1'b1;
            w_tx_nx    = w_nxt_bit;
          end
        end
      end
      S_PAR: begin
        if (w_tick) begin
          w_state_nx = S_STOP;
          w_bit_nx   = '0;
          w_tx_nx    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit == STOP_LAST) begin
            w_bit_nx = '0;
            // Chain straight into the next frame when a word is waiting.
            if (!w_empty) begin
              w_pop      = 1'b1;
              w_state_nx = S_START;
              w_tx_nx    = 1'b0;
            end else begin
              w_state_nx = S_IDLE;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_bit_nx = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, baud divider and configurable frame format; successor to the single-word `tx` block. It sits between a word producer using the `tx_rdy`/`tx_ack` handshake and the serial `tx` pin. It buffers up to `FIFO_DEPTH` words and sends them back-to-back as frames: start bit, data bits, optional parity bit, then stop bits.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, "ODD": "NONE", "ODD" or "EVEN".
- `STOP_BIT`, 1: stop bits, 1 or 2.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit, >=1. A value of 1 reproduces the legacy one-bit-per-clock timing.
- `FIFO_DEPTH`, 4: FIFO entries; power of 2, >=2.
- `LSB_FIRST`, 1: 1 = LSB first, 0 = MSB first.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `tx_data` in DATA_BITS: word to send; sampled when accepted.
- `tx_rdy` in 1: producer has a word on `tx_data`.
- `tx_ack` out 1: one-cycle pulse, word accepted.
- `tx` out 1: serial line; idle high; registered.
- `tx_busy` out 1: serializer is not in IDLE.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupied entries.
- `fifo_full` out 1: `fifo_count == FIFO_DEPTH`.

## Operation
- Reset values: `tx`=1, `tx_ack`=0, `tx_busy`=0, `fifo_count`=0, `fifo_full`=0, FSM in IDLE. Reset flushes the FIFO.
- Accept condition at a rising edge: `tx_rdy && !tx_ack && !fifo_full`.
  - `tx_data` is written to the FIFO at that edge.
  - `tx_ack` is registered high for exactly the following cycle.
  - `!tx_ack` blocks a double accept while the producer is still reacting to the ack.
  - `fifo_full` is evaluated on current state, so a pop at the same edge does not free space for that accept.
- FIFO: circular buffer; pointers wrap modulo `FIFO_DEPTH`. Push and pop at the same edge leave `fifo_count` unchanged.
- Serializer states: IDLE, START, DATA, PAR, STOP. A baud counter runs 0..CLKS_PER_BIT-1 and a bit counter tracks position.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, latch parity, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out DATA_BITS bits, each for CLKS_PER_BIT cycles, in the order set by LSB_FIRST. Then go to PAR, or to STOP if PARITY="NONE".
  - PAR: sends the parity bit for one bit time.
    - ODD: data bits plus parity bit contain an odd number of 1s (parity = ~^data).
    - EVEN: parity = ^data.
  - STOP: `tx`=1 for STOP_BIT bit times. On the final cycle, if the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!="NONE")+STOP_BIT) cycles.
- Reset mid-frame: at the next edge `tx`=1, FSM in IDLE, FIFO empty, any `tx_ack` pulse is cancelled.
- Parameter values outside the legal ranges are not supported. An elaboration check stops the build.

## Timing
- Throughput at the input: at most one accept every 2 cycles.
- Latency from an idle, empty block: word accepted at edge A; FIFO pops at edge A+1; `tx` goes low from edge A+1. From a full FIFO, data waits in order (first in, first out).
- Every bit lasts exactly CLKS_PER_BIT cycles, with no jitter, across consecutive frames.
- `tx_busy` rises at the pop edge and falls at the edge that enters IDLE.
- `fifo_count` and `fifo_full` update at the push/pop edge.

## Test plan
- Single frame, defaults: accept 0x01 -> `tx` shows 0, then 1,0,0,0,0,0,0,0, then parity 0, then stop 1, 176 cycles in total; then `tx_busy`=0.
- FIFO fill: producer increments data from 0x01 on every ack, starting while idle.
  - Required: acks until `fifo_full`=1 with 4 entries queued behind the frame in flight.
  - Required: the next ack only after a pop.
  - Required: frames carry 0x01, 0x02, ... in order, back-to-back with no idle cycles between stop and start.
- Format variants:
  - PARITY="EVEN", STOP_BIT=2, DATA_BITS=7, LSB_FIRST=0, word 0x55 -> start, then 1,0,1,0,1,0,1, then parity 0, then two stop bits.
  - PARITY="NONE" -> 10 bit times per frame at DATA_BITS=8.
- CLKS_PER_BIT=1, PARITY="ODD", STOP_BIT=1 -> one bit per clock, 11-cycle frames; matches the legacy transmitter waveform for the same data.
- Reset mid-frame in the DATA state with 2 words queued -> next cycle `tx`=1, `fifo_count`=0, `tx_busy`=0. No further frame is sent until a new accept.
- Push and pop on the same edge with `fifo_count`=2 -> `fifo_count` stays 2; order is preserved.
